// File: rtl/bus_responder.sv
// bus_responder: tagged 8-beat burst memory target; first read beat appears RESP_LATENCY cycles after accept.
// reqack only in IDLE/WR_DATA, read beats held until respack; define BUS_RESP_CWF_EN for critical-word-first reads.
module bus_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int RESP_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(RESP_LATENCY - 1);
  localparam logic [BUS_DATA_WIDTH-4:0] MEM_WORDS_W = (BUS_DATA_WIDTH-3)'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WR_DATA, LAT_WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [BUS_DATA_WIDTH-7:0] blk_q;
  logic [2:0]                off_q;
  logic [2:0]                beat_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic [LW-1:0]             lat_q;
  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                      xfer;
  logic [2:0]                rd_slot;
  logic [BUS_DATA_WIDTH-4:0] wr_full, rd_full;
  logic [AW-1:0]             wr_idx, rd_idx;

  assign xfer = bus_reqcyc && bus_reqack;

`ifdef BUS_RESP_CWF_EN
  assign rd_slot = off_q + beat_q;
`else
  assign rd_slot = beat_q;
  logic unused_off;
  assign unused_off = ^off_q;
`endif

  // Block words are contiguous, so the word index is just {block, slot}, wrapped into the array.
  assign wr_full = {blk_q, beat_q} % MEM_WORDS_W;
  assign rd_full = {blk_q, rd_slot} % MEM_WORDS_W;
  assign wr_idx  = wr_full[AW-1:0];
  assign rd_idx  = rd_full[AW-1:0];

  logic unused_hi;
  assign unused_hi = ^{wr_full[BUS_DATA_WIDTH-4:AW], rd_full[BUS_DATA_WIDTH-4:AW]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (xfer) state_nxt = bus_reqtag[12] ? WR_DATA : LAT_WAIT;
      WR_DATA:  if (xfer && beat_q == 3'd7) state_nxt = IDLE;
      LAT_WAIT: if (lat_q == LAT_LAST) state_nxt = RESP;
      RESP:     if (bus_respack && beat_q == 3'd7) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_reqack  = bus_reqcyc && (state == IDLE || state == WR_DATA);
    bus_respcyc = (state == RESP);
    bus_resp    = bus_respcyc ? mem[rd_idx] : '0;
    bus_resptag = bus_respcyc ? tag_q : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_q  <= '0;
      off_q  <= '0;
      beat_q <= '0;
      tag_q  <= '0;
      lat_q  <= '0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          blk_q  <= bus_req[BUS_DATA_WIDTH-1:6];
          off_q  <= bus_req[5:3];
          tag_q  <= bus_reqtag;
          beat_q <= '0;
          lat_q  <= '0;
        end
        WR_DATA:  if (xfer) beat_q <= beat_q + 3'd1;
        LAT_WAIT: lat_q <= lat_q + 1'b1;
        RESP:     if (bus_respack) beat_q <= beat_q + 3'd1;
        default:  ;
      endcase
    end
  end

  // Backing store is never reset, so a burst cut short by reset keeps the beats already written.
  always_ff @(posedge clk) begin
    if (state == WR_DATA && xfer) mem[wr_idx] <= bus_req;
  end

endmodule

// File: tb/tb_bus_responder.sv
// Randomised bench for bus_responder against a word-array memory model; follows BUS_RESP_CWF_EN like the design.
module tb_bus_responder;
  localparam int W   = 64;
  localparam int TW  = 13;
  localparam int MW  = 64;
  localparam int LAT = 4;

  logic          clk;
  logic          rst_n;
  logic          bus_reqcyc;
  logic [W-1:0]  bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [W-1:0]  bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;

  bus_responder #(.BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(TW), .MEM_WORDS(MW), .RESP_LATENCY(LAT)) dut (
    .clk(clk), .reset(rst_n),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] model [MW];
  logic [W-1:0] wdata [8];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word address of burst slot i inside the 64-byte block holding addr, wrapped into the array.
  function automatic int word_of(input logic [W-1:0] addr, input int i);
    logic [W-1:0] w;
    w = (addr >> 6) * 8 + W'(i);
    return int'(w % MW);
  endfunction

  function automatic int rd_slot(input logic [W-1:0] addr, input int i);
`ifdef BUS_RESP_CWF_EN
    return (int'((addr >> 3) % 8) + i) % 8;
`else
    return i;
`endif
  endfunction

  task automatic wait_ack(input string tag);
    int n = 0;
    #1;
    while (!bus_reqack && n < 64) begin
      @(negedge clk); #1; n++;
    end
    if (!bus_reqack) check(tag, bus_reqack, 1'b1);
  endtask

  // Address beat plus nbeats data beats from wdata; model tracks only beats actually accepted.
  task automatic wr(input logic [W-1:0] addr, input int nbeats, output int acks);
    acks = 0;
    for (int b = 0; b <= nbeats; b++) begin
      @(negedge clk);
      bus_reqcyc = 1'b1;
      bus_req    = (b == 0) ? addr : wdata[b-1];
      bus_reqtag = {1'b1, 12'($urandom)};
      wait_ack("wr_ack");
      if (bus_reqack) begin
        acks++;
        if (b > 0) model[word_of(addr, b-1)] = wdata[b-1];
      end
    end
    @(negedge clk);
    bus_reqcyc = 1'b0;
  endtask

  task automatic rd_issue(input logic [W-1:0] addr, input logic [TW-1:0] tag);
    @(negedge clk);
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    wait_ack("rd_ack");
  endtask

  // Entered just before the accept edge; optionally holds a second request to probe reqack.
  task automatic rd_collect(input logic [W-1:0] addr, input logic [TW-1:0] tag,
                            input int stall_beat, input int stall_n,
                            input bit probe, input logic [W-1:0] paddr, input logic [TW-1:0] ptag);
    int lat = 0;
    logic [W-1:0] exp;
    @(negedge clk);
    if (probe) begin
      bus_reqcyc = 1'b1; bus_req = paddr; bus_reqtag = ptag;
    end else bus_reqcyc = 1'b0;
    #1;
    while (!bus_respcyc && lat < 64) begin
      if (probe) check("probe_nack_lat", bus_reqack, 1'b0);
      bus_respack = 1'($urandom);
      @(negedge clk); #1; lat++;
    end
    check("rd_latency", lat, LAT);
    if (!bus_respcyc) return;
    for (int i = 0; i < 8; i++) begin
      exp = model[word_of(addr, rd_slot(addr, i))];
      check("rd_beat", bus_resp, exp);
      check("rd_tag", bus_resptag, tag);
      if (probe) check("probe_nack_resp", bus_reqack, 1'b0);
      if (i == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          bus_respack = 1'b0;
          @(negedge clk); #1;
          check("stall_hold", bus_resp, exp);
          check("stall_cyc", bus_respcyc, 1'b1);
        end
      end
      bus_respack = 1'b1;
      @(negedge clk); #1;
    end
    bus_respack = 1'b0;
    check("resp_done", bus_respcyc, 1'b0);
    check("resp_zero", bus_resp, '0);
    if (probe) check("probe_ack", bus_reqack, 1'b1);
  endtask

  task automatic rd(input logic [W-1:0] addr, input logic [TW-1:0] tag, input int stall_beat, input int stall_n);
    rd_issue(addr, tag);
    rd_collect(addr, tag, stall_beat, stall_n, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acks;
    int lat;
    logic [W-1:0] a, a2;
    logic [TW-1:0] t, t2;

    rst_n = 1'b0; bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b0;
    #3;
    check("rst_respcyc", bus_respcyc, 1'b0);
    check("rst_resp", bus_resp, '0);
    check("rst_resptag", bus_resptag, '0);
    check("rst_reqack", bus_reqack, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Fill the whole array so every later read has a known value.
    for (int blk = 0; blk < MW / 8; blk++) begin
      for (int k = 0; k < 8; k++) wdata[k] = {$urandom, $urandom};
      wr(W'(blk * 64), 8, acks);
      check("fill_acks", acks, 9);
    end

    for (int k = 0; k < 8; k++) wdata[k] = W'(8'h11 * (k + 1));
    wr(64'h40, 8, acks);
    check("wr_acks", acks, 9);
    rd(64'h40, 13'h0005, 8, 0);
    rd(64'h58, 13'h0006, 8, 0);
    rd(64'h40, 13'h0009, 2, 3);

    // Request held during a read is refused until the cycle after the last beat.
    rd_issue(64'h40, 13'h0011);
    rd_collect(64'h40, 13'h0011, 8, 0, 1'b1, 64'h58, 13'h0012);
    rd_collect(64'h58, 13'h0012, 8, 0, 1'b0, '0, '0);

    for (int k = 0; k < 8; k++) wdata[k] = {$urandom, $urandom};
    wr(64'h40 + 8 * MW, 8, acks);
    rd(64'h40, 13'h0013, 8, 0);

    // Reset on read beat 3: outputs drop immediately, next read is clean.
    rd_issue(64'h40, 13'h0007);
    @(negedge clk); bus_reqcyc = 1'b0; #1;
    lat = 0;
    while (!bus_respcyc && lat < 64) begin @(negedge clk); #1; lat++; end
    for (int i = 0; i < 3; i++) begin bus_respack = 1'b1; @(negedge clk); #1; end
    bus_respack = 1'b0;
    check("pre_rst_beat3", bus_resp, model[word_of(64'h40, rd_slot(64'h40, 3))]);
    rst_n = 1'b0; #1;
    check("midrst_respcyc", bus_respcyc, 1'b0);
    check("midrst_resp", bus_resp, '0);
    check("midrst_resptag", bus_resptag, '0);
    @(negedge clk); rst_n = 1'b1;
    rd(64'h40, 13'h0008, 8, 0);

    // Reset after four write data beats: those four stick, the rest keep old data.
    for (int k = 0; k < 8; k++) wdata[k] = {$urandom, $urandom};
    wr(64'h80, 4, acks);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rd(64'h80, 13'h0014, 8, 0);

    for (int it = 0; it < 24; it++) begin
      a = {$urandom, $urandom};
      t = {1'b0, 12'($urandom)};
      case ($urandom % 3)
        0: begin
          for (int k = 0; k < 8; k++) wdata[k] = {$urandom, $urandom};
          wr(a, 8, acks);
          check("rnd_wr_acks", acks, 9);
        end
        1: rd(a, t, int'($urandom % 8), int'($urandom % 3));
        default: begin
          a2 = {$urandom, $urandom};
          t2 = {1'b0, 12'($urandom)};
          rd_issue(a, t);
          rd_collect(a, t, int'($urandom % 8), int'($urandom % 3), 1'b1, a2, t2);
          rd_collect(a2, t2, 8, 0, 1'b0, '0, '0);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, data/address beat width.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, tag width.
REQ-003 SHALL have parameter MEM_WORDS, default 4096, number of 64-bit words of backing store.
REQ-004 SHALL have parameter RESP_LATENCY, default 4 (legal >=1), cycles from address accept to first read beat.
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port bus_reqcyc, input, 1, initiator request valid.
REQ-008 SHALL have port bus_req, input, BUS_DATA_WIDTH, byte address beat or write-data beat.
REQ-009 SHALL have port bus_reqtag, input, BUS_TAG_WIDTH, request tag; bit [12]=1 write, 0 read.
REQ-010 SHALL have port bus_reqack, output, 1, request beat accepted.
REQ-011 SHALL have port bus_respcyc, output, 1, response beat valid.
REQ-012 SHALL have port bus_resp, output, BUS_DATA_WIDTH, read-data beat.
REQ-013 SHALL have port bus_resptag, output, BUS_TAG_WIDTH, response tag.
REQ-014 SHALL have port bus_respack, input, 1, initiator consumed response beat.

Function
REQ-015 SHALL implement states IDLE, WR_DATA, LAT_WAIT, RESP.
REQ-016 SHALL drive bus_reqack combinationally = bus_reqcyc && state in {IDLE, WR_DATA}; a beat transfers on an edge with bus_reqcyc && bus_reqack.
REQ-017 IDLE + transfer: SHALL capture block base (bus_req & ~63), word offset bus_req[5:3], tag; read -> LAT_WAIT, write -> WR_DATA.
REQ-018 WR_DATA: each transfer SHALL write bus_req to word (base>>3)+beat, beat 0..7; after beat 7 -> IDLE; no write response issued.
REQ-019 LAT_WAIT: SHALL count RESP_LATENCY edges after accept edge, then assert bus_respcyc and enter RESP.
REQ-020 RESP: SHALL hold bus_resp, bus_resptag (= captured tag) stable while bus_respcyc && !bus_respack; advance beat on edge with bus_respack.
REQ-021 After 8th acked beat, bus_respcyc SHALL be 0 next cycle and state IDLE; back-to-back request accepted that cycle.
REQ-022 Word index SHALL be taken modulo MEM_WORDS (address wrap, no error).
REQ-023 bus_reqcyc while in LAT_WAIT/RESP SHALL see bus_reqack=0 and be held until IDLE.
REQ-024 bus_respack while bus_respcyc=0 SHALL be ignored.
REQ-025 bus_resp SHALL be 0 whenever bus_respcyc=0.

Reset
REQ-026 reset low SHALL immediately force state IDLE, bus_respcyc=0, bus_resp=0, bus_resptag=0, beat and latency counters 0.
REQ-027 Reset mid-burst SHALL abandon the burst; partially written words keep their written values; memory array not cleared.

Configuration
REQ-028 Macro BUS_RESP_CWF_EN defined: read beat i SHALL return word base+((offset+i) mod 8) (critical word first, wrap in block).
REQ-029 Macro undefined: read beat i SHALL return word base+i; offset ignored.

Verification
REQ-030 Write tag 0x1000 addr 0x40, data 0x11..0x88 -> 9 acks, then read tag 0x0005 addr 0x40 -> respcyc exactly 4 edges after accept, beats 0x11..0x88, resptag 0x0005.
REQ-031 With BUS_RESP_CWF_EN, read addr 0x58 of above block -> beats 0x44,0x55,0x66,0x77,0x88,0x11,0x22,0x33; without macro -> 0x11..0x88.
REQ-032 Read with respack low for 3 cycles at beat 2 -> bus_resp holds beat-2 value 3 cycles, total 8 beats, then respcyc=0.
REQ-033 Request during RESP -> bus_reqack=0 until cycle after 8th beat ack, then accepted.
REQ-034 Write addr 0x40+8*MEM_WORDS -> read addr 0x40 returns written data (wrap).
REQ-035 reset low during beat 3 of RESP -> bus_respcyc=0 same cycle, state IDLE, next read completes normally.
